// File: rtl/ethcrc_pkg.sv
// ethcrc_pkg
// Shared Ethernet CRC-32 constants and helpers used by the receive checker
// and the transmit inserter.
//   TAPS     : reflected CRC-32 polynomial
//   RESIDUE  : register value after a good frame plus its FCS (no final inversion)
//   CRC_INIT : register value at the start of every frame
//   MINLEN   : minimum frame length in bytes including FCS (runt check only)
//   crc_table_entry() : one entry of the 256-entry byte-wise CRC table
package ethcrc_pkg;

    localparam logic [31:0] TAPS     = 32'hedb88320;
    localparam logic [31:0] RESIDUE  = 32'hdebb20e3;
    localparam logic [31:0] CRC_INIT = 32'hffffffff;
    localparam logic [10:0] MINLEN   = 11'd64;

    // Entry idx of the byte-wise table: eight bit-serial shifts of the index
    // through the reflected polynomial. Used as combinational logic, so the
    // table is never stored as a ROM.
    function automatic logic [31:0] crc_table_entry(input logic [7:0] idx);
        logic [31:0] c;
        c = {24'h0, idx};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ TAPS) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rxecrc_if.sv
// rxecrc_if
// Byte-stream bundle around the receive CRC checker.
//   i_en   : 1 = check and strip FCS, 0 = pass-through
//   i_v/i_d: input byte valid / byte
//   o_v/o_d: output byte valid / byte (FCS removed when i_en=1)
//   o_done : one-cycle end-of-frame strobe
//   o_err  : CRC or length failure, meaningful only with o_done
// master drives the inputs (upstream stage or bench), slave is the checker.
interface rxecrc_if;
    logic       i_en;
    logic       i_v;
    logic [7:0] i_d;
    logic       o_v;
    logic [7:0] o_d;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_en, i_v, i_d,
        input  o_v, o_d, o_done, o_err
    );

    modport slave (
        input  i_en, i_v, i_d,
        output o_v, o_d, o_done, o_err
    );
endinterface

// File: rtl/crc32_byte.sv
// crc32_byte
// Combinational one-byte step of the reflected CRC-32.
//   crc_i  : current CRC register
//   data_i : byte being absorbed
//   crc_o  : CRC register after absorbing data_i
module crc32_byte
    import ethcrc_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    assign crc_o = {8'h0, crc_i[31:8]} ^ crc_table_entry(crc_i[7:0] ^ data_i);

endmodule

// File: rtl/rxecrc.sv
// rxecrc
// Receive-side Ethernet CRC-32 checker. Runs the CRC over every byte of a
// frame including the FCS, strips the FCS through a 4-byte delay line and
// flags the frame at its end.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   bus     : rxecrc_if.slave byte stream (i_en, i_v, i_d, o_v, o_d, o_done, o_err)
// Optional build macro RXECRC_MINLEN_EN: also flags frames shorter than MINLEN.
module rxecrc
    import ethcrc_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    rxecrc_if.slave  bus
);

    logic [31:0] crc_q,    crc_d;
    logic [31:0] crc_next;
    logic [2:0]  fill_q,   fill_d;
    logic [10:0] len_q,    len_d;
    logic [7:0]  dly_q [4];
    logic [7:0]  dly_d [4];
    logic        vprev_q,  vprev_d;
    logic        ov_q,     ov_d;
    logic [7:0]  od_q,     od_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;
    logic        frame_end;
    logic        len_short;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (bus.i_d),
        .crc_o  (crc_next)
    );

    // Frame end is the first idle cycle after a valid one; vprev_q remembers
    // the previous cycle's valid so an idle line never strobes.
    always_comb begin
        frame_end = vprev_q & ~bus.i_v;
`ifdef RXECRC_MINLEN_EN
        len_short = (len_q < 11'd4) || (len_q < MINLEN);
`else
        len_short = (len_q < 11'd4);
`endif
    end

    // Next-state: absorb accepted bytes, release the oldest delayed byte once
    // the line holds four, and reinitialise on the end-of-frame cycle so a new
    // frame may start immediately after the strobe.
    always_comb begin
        crc_d   = crc_q;
        fill_d  = fill_q;
        len_d   = len_q;
        dly_d   = dly_q;
        vprev_d = bus.i_v;
        ov_d    = 1'b0;
        od_d    = 8'h00;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (bus.i_v) begin
            crc_d    = crc_next;
            dly_d[0] = bus.i_d;
            for (int i = 1; i < 4; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
            if (len_q != 11'd2047) begin
                len_d = len_q + 11'd1;
            end
            if (fill_q == 3'd4) begin
                ov_d = 1'b1;
                od_d = dly_q[3];
            end
        end else if (frame_end) begin
            crc_d  = CRC_INIT;
            fill_d = 3'd0;
            len_d  = 11'd0;
            for (int i = 0; i < 4; i++) begin
                dly_d[i] = 8'h00;
            end
            done_d = 1'b1;
            err_d  = bus.i_en & ((crc_q != RESIDUE) | len_short);
        end

        // Pass-through mode overrides the stripped stream with a plain
        // one-cycle register of the input.
        if (!bus.i_en) begin
            ov_d = bus.i_v;
            od_d = bus.i_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            crc_q   <= CRC_INIT;
            fill_q  <= 3'd0;
            len_q   <= 11'd0;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= 8'h00;
            end
            vprev_q <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            dly_q   <= dly_d;
            vprev_q <= vprev_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_v    = ov_q;
    assign bus.o_d    = od_q;
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;

endmodule

// File: doc/rxecrc.md
Name: rxecrc

Overview:
Receive-side Ethernet CRC-32 checker for byte streams from the RMII/MII nibble-to-byte stage. Sits upstream of the packet buffer.
- Computes the reflected CRC-32 over every byte of a frame, including the trailing 4-byte FCS.
- Strips the FCS from the output stream through a 4-byte delay line.
- At end of frame, pulses a done strobe and an error flag.

Parameters:
TAPS, 32'hedb88320, reflected CRC-32 polynomial.
RESIDUE, 32'hdebb20e3, CRC register value after a good frame plus FCS (no final inversion).
MINLEN, 64, minimum frame length in bytes including FCS; used only with the optional feature.

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active-high
i_en  input  1  1 = check and strip FCS; 0 = pass-through. Held stable while a frame is active.
i_v  input  1  input byte valid; continuous for a whole frame; first low ends the frame
i_d  input  8  input byte
o_v  output  1  output byte valid
o_d  output  8  output byte (frame without FCS)
o_done  output  1  one-cycle end-of-frame strobe
o_err  output  1  valid only with o_done; 1 = CRC or length failure

Behaviour:
- Reset: o_v=0, o_d=0, o_done=0, o_err=0; CRC register=32'hffffffff; fill count=0; length count=0; delay line cleared.
- Per accepted byte (i_v=1):
  - crc <= {8'h0, crc[31:8]} ^ table[crc[7:0]^i_d], where table is the byte-wise expansion of TAPS.
  - Push i_d into the 4-deep delay line; fill count saturates at 4.
  - Length count increments and saturates at 2047.
- Output with i_en=1:
  - o_v=1 on the cycle after a byte is accepted while fill count==4 (i.e. input byte 5 onward).
  - o_d = byte leaving the delay line. Output byte k appears one clock after input byte k+4.
  - The final 4 bytes (the FCS) are never output.
- Output with i_en=0:
  - o_v/o_d register i_v/i_d with 1-cycle latency; no stripping.
  - o_done still pulses at end of frame; o_err=0.
- End of frame: the first cycle with i_v=0 after i_v=1 (registered edge).
  - o_done=1 for one cycle, on the same clock that o_v drops.
  - o_err = (crc != RESIDUE) || (length < 4).
  - The CRC register, fill count, length count and delay line reinitialise on that same cycle.
- A 1–3 byte frame: no o_v output, o_done with o_err=1.
- A zero-length idle produces no strobe.
- i_reset mid-frame: the frame is discarded, no o_done, state returns to reset values. A new frame may begin on the cycle after reset deasserts.
- Back-to-back frames need at least one idle cycle between them. A new frame starting on the cycle after o_done is legal.

Optional Feature:
RXECRC_MINLEN_EN.
- Defined: o_err also asserts when length count < MINLEN (runt frame).
- Undefined: no length check beyond the 4-byte minimum; the MINLEN parameter is unused.

Decomposition:
- Shared package ethcrc_pkg holds TAPS, RESIDUE, the CRC init value 32'hffffffff, and the function building the 256-entry table. The transmit CRC inserter uses the same package.
- One sub-module, crc32_byte: combinational next-CRC from (crc, byte), shared with the transmit side.
- The delay line and control stay in rxecrc.

Test Plan:
1. i_en=1, frame "123456789" (31..39) followed by 26 39 F4 CB: o_v for exactly 9 bytes, o_d=31..39, then o_done=1 and o_err=0. CRC register equals 32'hdebb20e3 before reinit.
2. Same frame with the last FCS byte changed to CA: the same 9 bytes are output, o_done=1 with o_err=1.
3. 3-byte frame AA BB CC: o_v never asserts; o_done=1, o_err=1.
4. i_en=0, 5-byte frame 01..05: o_d=01..05 with 1-cycle latency, then o_done=1 with o_err=0.
5. i_reset asserted after byte 6 of a 60-byte frame: no o_done; all outputs 0 the next cycle. The following good frame is checked with o_err=0.
6. With RXECRC_MINLEN_EN: a valid-CRC 60-byte frame gives o_err=1; a valid 64-byte frame gives o_err=0 and 60 output bytes.
